ram_access_seq: RTL and testbench

Upstream access sequencer for the dual 16x4 RAM stage: it drives the shared address and data bus and the two per-RAM write enables. In idle it passes the switch-level manual controls through. On a start pulse it runs one of three automatic sweeps over all addresses: pattern fill, timed display scan, or RAM0-to-RAM1 copy. The RAM read ports return to it for scan display and copy.

---
 rtl/ram_access_seq.sv | 196 +++++++++++++++++++
 tb/tb_ram_access_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// ram_access_seq : shared address/data/write-enable sequencer for the dual RAM
//                  stage (manual pass-through, pattern fill, scan, copy)
// Revision       : 1.0
// ----------------------------------------------------------------------------
module ram_access_seq #(
   parameter int AW     = 4,
   parameter int DW     = 4,
   parameter int DWELL  = 25_000_000,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_start,
   input  logic          i_abort,
   input  logic [1:0]    i_op,
   input  logic          i_sel,
   input  logic [AW-1:0] i_man_addr,
   input  logic [DW-1:0] i_man_data,
   input  logic          i_man_wr,
   input  logic [DW-1:0] i_pat_seed,
   input  logic [DW-1:0] i_rd_data0,
   input  logic [DW-1:0] i_rd_data1,
   output logic [AW-1:0] o_addr,
   output logic [DW-1:0] o_mdi,
   output logic          o_mwr0,
   output logic          o_mwr1,
   output logic [DW-1:0] o_cur_data,
   output logic          o_busy,
   output logic          o_done
);

   localparam int               c_dcw        = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [c_dcw-1:0] c_dwell_last = c_dcw'(DWELL - 1);
   localparam logic [1:0]       c_lat_last   = 2'(RD_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_SCAN  = 3'd2,
      S_CP_RD = 3'd3,
      S_CP_WR = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t           r_state,  w_state_nx;
   logic [AW-1:0]    r_idx,    w_idx_nx;
   logic [c_dcw-1:0] r_dwell,  w_dwell_nx;
   logic [1:0]       r_lat,    w_lat_nx;
   logic [AW-1:0]    r_addr,   w_addr_nx;
   logic [DW-1:0]    r_mdi,    w_mdi_nx;
   logic             r_mwr0,   w_mwr0_nx;
   logic             r_mwr1,   w_mwr1_nx;
   logic [DW-1:0]    r_cur,    w_cur_nx;
   logic             r_busy,   w_busy_nx;
   logic             r_done,   w_done_nx;
   logic             w_last;

   assign w_last = &r_idx;

   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_dwell_nx = r_dwell;
      w_lat_nx   = r_lat;
      w_addr_nx  = r_addr;
      w_mdi_nx   = r_mdi;
      w_mwr0_nx  = 1'b0;
      w_mwr1_nx  = 1'b0;
      w_cur_nx   = r_cur;
      w_busy_nx  = 1'b0;
      w_done_nx  = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_addr_nx  = i_man_addr;
            w_mdi_nx   = i_man_data;
            w_mwr0_nx  = i_man_wr & ~i_sel;
            w_mwr1_nx  = i_man_wr &  i_sel;
            w_idx_nx   = '0;
            w_dwell_nx = '0;
            w_lat_nx   = '0;
            if (i_start) begin
               case (i_op)
                  2'b01:   w_state_nx = S_FILL;
                  2'b10:   w_state_nx = S_SCAN;
                  2'b11:   w_state_nx = S_CP_RD;
                  default: w_state_nx = S_IDLE;
               endcase
            end
         end

         S_FILL: begin
            w_busy_nx = 1'b1;
            w_addr_nx = r_idx;
            w_mdi_nx  = i_pat_seed + DW'(r_idx);
            w_mwr0_nx = ~i_sel;
            w_mwr1_nx = i_sel;
            w_idx_nx  = r_idx + 1'b1;
            if (w_last) w_state_nx = S_DONE;
         end

         S_SCAN: begin
            w_busy_nx = 1'b1;
            w_addr_nx = r_idx;
            if (r_dwell == c_dwell_last) begin
               w_dwell_nx = '0;
               w_cur_nx   = i_sel ? i_rd_data1 : i_rd_data0;
               w_idx_nx   = r_idx + 1'b1;
               if (w_last) w_state_nx = S_DONE;
            end else begin
               w_dwell_nx = r_dwell + 1'b1;
            end
         end

         S_CP_RD: begin
            w_busy_nx = 1'b1;
            w_addr_nx = r_idx;
            if (r_lat == c_lat_last) begin
               w_lat_nx   = '0;
               w_state_nx = S_CP_WR;
            end else begin
               w_lat_nx = r_lat + 2'd1;
            end
         end

         S_CP_WR: begin
            // Sampling here gives the address RD_LAT full cycles on the bus.
            w_busy_nx = 1'b1;
            w_addr_nx = r_idx;
            w_mdi_nx  = i_rd_data0;
            w_mwr1_nx = 1'b1;
            w_idx_nx  = r_idx + 1'b1;
            w_state_nx = w_last ? S_DONE : S_CP_RD;
         end

         S_DONE: begin
            w_done_nx  = 1'b1;
            w_state_nx = S_IDLE;
         end

         default: w_state_nx = S_IDLE;
      endcase

      if (i_abort && (r_state != S_IDLE)) begin
         w_state_nx = S_IDLE;
         w_addr_nx  = r_addr;
         w_mdi_nx   = r_mdi;
         w_mwr0_nx  = 1'b0;
         w_mwr1_nx  = 1'b0;
         w_cur_nx   = r_cur;
         w_busy_nx  = 1'b0;
         w_done_nx  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_dwell <= '0;
         r_lat   <= '0;
         r_addr  <= '0;
         r_mdi   <= '0;
         r_mwr0  <= 1'b0;
         r_mwr1  <= 1'b0;
         r_cur   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
         r_dwell <= w_dwell_nx;
         r_lat   <= w_lat_nx;
         r_addr  <= w_addr_nx;
         r_mdi   <= w_mdi_nx;
         r_mwr0  <= w_mwr0_nx;
         r_mwr1  <= w_mwr1_nx;
         r_cur   <= w_cur_nx;
         r_busy  <= w_busy_nx;
         r_done  <= w_done_nx;
      end
   end

   assign o_addr     = r_addr;
   assign o_mdi      = r_mdi;
   assign o_mwr0     = r_mwr0;
   assign o_mwr1     = r_mwr1;
   assign o_cur_data = r_cur;
   assign o_busy     = r_busy;
   assign o_done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_access_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ram_access_seq : directed bench for ram_access_seq against a per-cycle
//                     expected-output trace built from the sweep rules
// Revision          : 1.0
// ----------------------------------------------------------------------------
module tb_ram_access_seq;

   localparam int AW = 4, DW = 4, DWELL = 4, RD_LAT = 1, N = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          i_start = 1'b0, i_abort = 1'b0, i_sel = 1'b0, i_man_wr = 1'b0;
   logic [1:0]    i_op = 2'b00;
   logic [AW-1:0] i_man_addr = '0;
   logic [DW-1:0] i_man_data = '0, i_pat_seed = '0;
   logic [DW-1:0] w_rd0, w_rd1;
   logic [AW-1:0] o_addr;
   logic [DW-1:0] o_mdi, o_cur_data;
   logic          o_mwr0, o_mwr1, o_busy, o_done;

   logic [DW-1:0] ram0 [N];
   logic [DW-1:0] ram1 [N];
   logic [DW-1:0] exp_ram0 [N];
   logic [DW-1:0] exp_ram1 [N];

   typedef struct {
      logic [3:0] addr;
      logic [3:0] mdi;
      logic       w0;
      logic       w1;
      logic       busy;
      logic       done;
      logic [3:0] cur;
      bit         ca;
      bit         cm;
   } rec_t;

   rec_t       exp_q [$];
   int         n_checks = 0;
   int         n_errors = 0;
   logic [3:0] exp_cur = 4'h0;

   always #5 clk = ~clk;

   ram_access_seq #(.AW(AW), .DW(DW), .DWELL(DWELL), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .i_op(i_op),
      .i_sel(i_sel), .i_man_addr(i_man_addr), .i_man_data(i_man_data), .i_man_wr(i_man_wr),
      .i_pat_seed(i_pat_seed), .i_rd_data0(w_rd0), .i_rd_data1(w_rd1),
      .o_addr(o_addr), .o_mdi(o_mdi), .o_mwr0(o_mwr0), .o_mwr1(o_mwr1),
      .o_cur_data(o_cur_data), .o_busy(o_busy), .o_done(o_done)
   );

   // Asynchronous-read RAM pair driven by the DUT's shared bus.
   assign w_rd0 = ram0[o_addr];
   assign w_rd1 = ram1[o_addr];
   always @(posedge clk) begin
      if (o_mwr0) ram0[o_addr] <= o_mdi;
      if (o_mwr1) ram1[o_addr] <= o_mdi;
   end

   function automatic void check(input string name, input logic [3:0] act, input logic [3:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endfunction

   initial begin
      rec_t r;
      forever begin
         @(posedge clk);
         #1;
         check("wr_exclusive", 4'(o_mwr0 & o_mwr1), 4'h0);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL trace: no expectation for cycle at %0t", $time);
         end else begin
            r = exp_q.pop_front();
            check("busy", 4'(o_busy), 4'(r.busy));
            check("done", 4'(o_done), 4'(r.done));
            check("mwr0", 4'(o_mwr0), 4'(r.w0));
            check("mwr1", 4'(o_mwr1), 4'(r.w1));
            check("cur_data", o_cur_data, r.cur);
            if (r.ca) check("addr", o_addr, r.addr);
            if (r.cm) check("mdi", o_mdi, r.mdi);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete at %0t", $time);
      $fatal(1);
   end

   function automatic rec_t man_rec();
      rec_t r;
      r = '{addr: i_man_addr, mdi: i_man_data, w0: i_man_wr & ~i_sel, w1: i_man_wr & i_sel,
            busy: 1'b0, done: 1'b0, cur: exp_cur, ca: 1'b1, cm: 1'b1};
      return r;
   endfunction

   function automatic rec_t zero_rec();
      rec_t r;
      r = '{addr: 4'h0, mdi: 4'h0, w0: 1'b0, w1: 1'b0, busy: 1'b0, done: 1'b0,
            cur: 4'h0, ca: 1'b1, cm: 1'b1};
      return r;
   endfunction

   task automatic push_step(input rec_t r);
      exp_q.push_back(r);
      if (r.w0) exp_ram0[r.addr] = r.mdi;
      if (r.w1) exp_ram1[r.addr] = r.mdi;
      @(negedge clk);
   endtask

   task automatic idle(input logic sel, input logic [3:0] a, input logic [3:0] d, input logic wr);
      i_sel      = sel;
      i_man_addr = a;
      i_man_data = d;
      i_man_wr   = wr;
      push_step(man_rec());
   endtask

   // Builds the whole expected trace of one sweep, then plays it cycle by
   // cycle, optionally cut short by abort or by an asynchronous reset.
   task automatic sweep(input logic [1:0] op, input logic sel, input logic [3:0] seed,
                        input int abort_at, input int rst_at, input int restart_at);
      rec_t       plan [$];
      rec_t       r;
      logic [3:0] c;
      bit         cut;
      c   = exp_cur;
      cut = 1'b0;
      for (int a = 0; a < N; a++) begin
         if (op == 2'b01) begin
            plan.push_back('{addr: 4'(a), mdi: seed + 4'(a), w0: ~sel, w1: sel,
                             busy: 1'b1, done: 1'b0, cur: c, ca: 1'b1, cm: 1'b1});
         end else if (op == 2'b10) begin
            for (int j = 0; j < DWELL; j++) begin
               if (j == DWELL - 1) c = sel ? exp_ram1[a] : exp_ram0[a];
               plan.push_back('{addr: 4'(a), mdi: 4'h0, w0: 1'b0, w1: 1'b0,
                                busy: 1'b1, done: 1'b0, cur: c, ca: 1'b1, cm: 1'b0});
            end
         end else begin
            for (int j = 0; j < RD_LAT; j++)
               plan.push_back('{addr: 4'(a), mdi: 4'h0, w0: 1'b0, w1: 1'b0,
                                busy: 1'b1, done: 1'b0, cur: c, ca: 1'b1, cm: 1'b0});
            plan.push_back('{addr: 4'(a), mdi: exp_ram0[a], w0: 1'b0, w1: 1'b1,
                             busy: 1'b1, done: 1'b0, cur: c, ca: 1'b1, cm: 1'b1});
         end
      end
      plan.push_back('{addr: 4'h0, mdi: 4'h0, w0: 1'b0, w1: 1'b0,
                       busy: 1'b0, done: 1'b1, cur: c, ca: 1'b0, cm: 1'b0});

      i_man_wr   = 1'b0;
      i_op       = op;
      i_sel      = sel;
      i_pat_seed = seed;
      i_start    = 1'b1;
      push_step(man_rec());
      i_start = 1'b0;
      for (int i = 0; i < plan.size(); i++) begin
         if (i == restart_at) i_start = 1'b1;
         if (i == abort_at) begin
            i_abort = 1'b1;
            r = '{addr: 4'h0, mdi: 4'h0, w0: 1'b0, w1: 1'b0, busy: 1'b0, done: 1'b0,
                  cur: (i == 0) ? exp_cur : plan[i-1].cur, ca: 1'b0, cm: 1'b0};
            push_step(r);
            i_abort = 1'b0;
            exp_cur = r.cur;
            cut     = 1'b1;
            break;
         end
         if (i == rst_at) begin
            #2 rst_n = 1'b0;
            #1;
            check("rst_async_addr", o_addr, 4'h0);
            check("rst_async_mdi", o_mdi, 4'h0);
            check("rst_async_mwr1", 4'(o_mwr1), 4'h0);
            check("rst_async_busy", 4'(o_busy), 4'h0);
            exp_cur = 4'h0;
            push_step(zero_rec());
            push_step(zero_rec());
            rst_n = 1'b1;
            cut   = 1'b1;
            break;
         end
         push_step(plan[i]);
         i_start = 1'b0;
      end
      if (!cut) exp_cur = plan[plan.size()-1].cur;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #2;
      check("reset_addr", o_addr, 4'h0);
      check("reset_mdi", o_mdi, 4'h0);
      check("reset_mwr0", 4'(o_mwr0), 4'h0);
      check("reset_mwr1", 4'(o_mwr1), 4'h0);
      check("reset_cur", o_cur_data, 4'h0);
      check("reset_busy", 4'(o_busy), 4'h0);
      check("reset_done", 4'(o_done), 4'h0);
      push_step(zero_rec());
      push_step(zero_rec());
      rst_n = 1'b1;

      // Manual pass-through
      idle(1'b1, 4'h5, 4'hA, 1'b1);
      check("man1_addr", o_addr, 4'h5);
      check("man1_mdi", o_mdi, 4'hA);
      check("man1_mwr1", 4'(o_mwr1), 4'h1);
      check("man1_mwr0", 4'(o_mwr0), 4'h0);
      idle(1'b0, 4'h5, 4'hA, 1'b1);
      check("man0_mwr0", 4'(o_mwr0), 4'h1);
      check("man0_mwr1", 4'(o_mwr1), 4'h0);
      idle(1'b0, 4'h0, 4'h0, 1'b0);

      // Fill RAM0 from seed E (wraps), with an ignored start mid-sweep
      sweep(2'b01, 1'b0, 4'hE, -1, -1, 3);
      idle(1'b0, 4'h0, 4'h0, 1'b0);
      check("fill_ram0_0", ram0[0], 4'hE);
      check("fill_ram0_1", ram0[1], 4'hF);
      check("fill_ram0_2", ram0[2], 4'h0);
      check("fill_ram0_15", ram0[15], 4'hD);

      // Preload RAM1 with addr^3 and scan it
      for (int a = 0; a < N; a++) idle(1'b1, 4'(a), 4'(a) ^ 4'h3, 1'b1);
      idle(1'b1, 4'h0, 4'h0, 1'b0);
      sweep(2'b10, 1'b1, 4'h0, -1, -1, -1);
      idle(1'b0, 4'h0, 4'h0, 1'b0);
      check("scan_final_cur", o_cur_data, 4'hC);

      // Preload RAM0 with 15-addr and copy to RAM1 (sel ignored)
      for (int a = 0; a < N; a++) idle(1'b0, 4'(a), 4'hF - 4'(a), 1'b1);
      idle(1'b0, 4'h0, 4'h0, 1'b0);
      sweep(2'b11, 1'b1, 4'h0, -1, -1, -1);
      idle(1'b0, 4'h0, 4'h0, 1'b0);
      check("copy_ram1_0", ram1[0], 4'hF);
      check("copy_ram1_15", ram1[15], 4'h0);

      // start with op=00 is ignored
      i_op    = 2'b00;
      i_start = 1'b1;
      idle(1'b0, 4'h3, 4'h9, 1'b0);
      i_start = 1'b0;
      idle(1'b0, 4'h3, 4'h9, 1'b0);
      idle(1'b0, 4'h0, 4'h0, 1'b0);

      // Abort fill into RAM1 at its sixth sweep cycle
      sweep(2'b01, 1'b1, 4'h3, 5, -1, -1);
      idle(1'b0, 4'h0, 4'h0, 1'b0);
      idle(1'b0, 4'h0, 4'h0, 1'b0);
      check("abort_ram1_4", ram1[4], 4'h7);
      check("abort_ram1_5", ram1[5], 4'hA);

      // Asynchronous reset during a copy
      sweep(2'b11, 1'b0, 4'h0, -1, 9, -1);
      idle(1'b0, 4'h7, 4'h2, 1'b0);
      check("post_rst_addr", o_addr, 4'h7);
      check("post_rst_mdi", o_mdi, 4'h2);
      idle(1'b0, 4'h0, 4'h0, 1'b0);
      check("rst_copy_ram1_3", ram1[3], 4'hC);
      check("rst_copy_ram1_4", ram1[4], 4'h7);

      for (int a = 0; a < N; a++) begin
         check("ram0_final", ram0[a], exp_ram0[a]);
         check("ram1_final", ram1[a], exp_ram1[a]);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
